// File: rtl/display_source_arbiter.sv
// display_source_arbiter: round-robin owner of the shared 8-digit seven-segment display.
// Each granted requester is shown for DWELL_CYCLES, then the display is blanked for
// GAP_CYCLES before the next arbitration, which happens only in IDLE.
// Ports:
//   clk_in    - system clock
//   rst_in    - asynchronous active-low reset
//   req_in    - per-requester level request
//   val_in    - requester i value at [32*i +: 32]
//   val_out   - value snapshot for the display controller
//   blank_out - display must be blanked (gap)
//   grant_out - one-hot current owner, 0 when none
//   done_out  - one-cycle pulse when a slot completes without withdrawal
//   busy_out  - arbiter is not idle
module display_source_arbiter #(
    parameter int          N_REQ        = 4,
    parameter int          DWELL_CYCLES = 50_000_000,
    parameter int          GAP_CYCLES   = 1_000_000,
    parameter logic [31:0] IDLE_VAL     = 32'h0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [N_REQ-1:0]     req_in,
    input  logic [32*N_REQ-1:0]  val_in,
    output logic [31:0]          val_out,
    output logic                 blank_out,
    output logic [N_REQ-1:0]     grant_out,
    output logic [N_REQ-1:0]     done_out,
    output logic                 busy_out
);
    localparam int MAXC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int PW   = $clog2(N_REQ);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = (GAP_CYCLES == 0) ? CW'(0) : CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      ptr_q, ptr_d, win_q, win_d;
    logic [31:0]        val_q, val_d;
    logic [N_REQ-1:0]   grant_q, grant_d, done_q, done_d;
    logic               blank_q, blank_d, busy_q, busy_d;

    logic               found, sel, show_end;
    logic [PW-1:0]      win;
    logic [PW:0]        idx;

    // Rotating priority scan starting at ptr_q; idx is one bit wider so the wrap is a subtract.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(N_REQ)) idx = idx - (PW+1)'(N_REQ);
            if (!found && req_in[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    assign sel      = (state_q == S_IDLE) && found;
    // Withdrawal and dwell expiry both end the slot; only expiry with request still held pulses done.
    assign show_end = (state_q == S_SHOW) && (!req_in[win_q] || cnt_q == DWELL_LAST);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            val_q   <= IDLE_VAL;
            grant_q <= '0;
            done_q  <= '0;
            blank_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            val_q   <= val_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            blank_q <= blank_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = (state_q == S_IDLE) ? (found ? S_SHOW : S_IDLE)
                : (state_q == S_SHOW) ? (show_end ? ((GAP_CYCLES == 0) ? S_IDLE : S_GAP) : S_SHOW)
                : ((cnt_q == GAP_LAST) ? S_IDLE : S_GAP);
    end

    always_comb begin
        cnt_d   = (state_d == state_q && state_q != S_IDLE) ? cnt_q + CW'(1) : '0;
        win_d   = sel ? win : win_q;
        ptr_d   = sel ? ((win == PW'(N_REQ - 1)) ? '0 : win + PW'(1)) : ptr_q;
        val_d   = sel ? val_in[32*win +: 32] : val_q;
        grant_d = (state_d != S_SHOW) ? '0 : sel ? (N_REQ'(1) << win) : grant_q;
        done_d  = (state_q == S_SHOW && req_in[win_q] && cnt_q == DWELL_LAST) ? grant_q : '0;
        blank_d = (state_d == S_GAP);
        busy_d  = (state_d != S_IDLE);
    end

    assign val_out   = val_q;
    assign grant_out = grant_q;
    assign done_out  = done_q;
    assign blank_out = blank_q;
    assign busy_out  = busy_q;
endmodule

// File: tb/tb_display_source_arbiter.sv
// tb_display_source_arbiter: scoreboard bench for display_source_arbiter (gap and no-gap instances).
module tb_display_source_arbiter;
    logic         clk_in = 1'b0;
    logic         rst_in = 1'b0;
    logic [3:0]   req_in = '0;
    logic [127:0] val_in = '0;
    logic [31:0]  val_out, z_val;
    logic [3:0]   grant_out, done_out, z_grant, z_done;
    logic         blank_out, busy_out, z_blank, z_busy;

    display_source_arbiter #(.N_REQ(4), .DWELL_CYCLES(4), .GAP_CYCLES(2), .IDLE_VAL(32'hDEAD_BEEF)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .val_in(val_in),
        .val_out(val_out), .blank_out(blank_out), .grant_out(grant_out),
        .done_out(done_out), .busy_out(busy_out));

    display_source_arbiter #(.N_REQ(4), .DWELL_CYCLES(4), .GAP_CYCLES(0), .IDLE_VAL(32'hDEAD_BEEF)) dut_nogap (
        .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .val_in(val_in),
        .val_out(z_val), .blank_out(z_blank), .grant_out(z_grant),
        .done_out(z_done), .busy_out(z_busy));

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  g;
        logic [31:0] v;
        int          gc;
        logic [3:0]  d;
        int          bc;
    } exp_t;
    exp_t sb[$];

    task automatic push(input logic [3:0] g, input logic [31:0] v, input int gc, input logic [3:0] d, input int bc);
        exp_t e;
        e.g = g; e.v = v; e.gc = gc; e.d = d; e.bc = bc;
        sb.push_back(e);
    endtask

    task automatic do_reset;
        rst_in = 1'b0;
        req_in = '0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (grant_out == '0 && n < 50) begin
            @(negedge clk_in);
            n++;
        end
    endtask

    // From a negedge inside a slot: count remaining grant cycles, then blank cycles, and collect done pulses.
    task automatic measure(output int gc, output logic [3:0] d, output int dc, output int bc);
        gc = 0; bc = 0; d = '0; dc = 0;
        while (grant_out != '0 && gc < 50) begin
            gc++;
            @(negedge clk_in);
        end
        while (blank_out && bc < 50) begin
            bc++;
            d |= done_out;
            dc += (done_out != '0) ? 1 : 0;
            @(negedge clk_in);
        end
        d |= done_out;
        dc += (done_out != '0) ? 1 : 0;
    endtask

    task automatic test_reset;
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            req_in = 4'($urandom);
            val_in = {4{$urandom}};
            @(negedge clk_in);
            total++;
            if (val_out !== 32'hDEAD_BEEF || {grant_out, done_out, busy_out, blank_out} !== 10'b0) begin
                bad++;
                $display("FAIL reset_hold: val=%h g=%b d=%b busy=%b blank=%b expected val=deadbeef all zero",
                         val_out, grant_out, done_out, busy_out, blank_out);
            end
        end
        total++;
        if (z_val !== 32'hDEAD_BEEF || {z_grant, z_done, z_busy, z_blank} !== 10'b0) begin
            bad++;
            $display("FAIL reset_nogap: val=%h g=%b d=%b busy=%b blank=%b expected val=deadbeef all zero",
                     z_val, z_grant, z_done, z_busy, z_blank);
        end
    endtask

    task automatic test_single;
        exp_t e;
        int n, gc, dc, bc;
        logic [3:0] d;
        do_reset;
        val_in = '0;
        val_in[32 +: 32] = 32'h1234_5678;
        req_in = 4'b0010;
        push(4'b0010, 32'h1234_5678, 4, 4'b0010, 2);
        push(4'b0010, 32'h1234_5678, 4, 4'b0010, 2);
        wait_grant(n);
        e = sb.pop_front();
        total++;
        if (grant_out !== e.g || val_out !== e.v || busy_out !== 1'b1) begin
            bad++;
            $display("FAIL single_grant: g=%b val=%h busy=%b expected g=%b val=%h busy=1", grant_out, val_out, busy_out, e.g, e.v);
        end
        measure(gc, d, dc, bc);
        total++;
        if (gc !== e.gc) begin
            bad++;
            $display("FAIL single_dwell: got %0d cycles expected %0d", gc, e.gc);
        end
        total++;
        if (d !== e.d || dc !== 1) begin
            bad++;
            $display("FAIL single_done: got %b over %0d cycles expected %b over 1", d, dc, e.d);
        end
        total++;
        if (bc !== e.bc) begin
            bad++;
            $display("FAIL single_gap: got %0d blank cycles expected %0d", bc, e.bc);
        end
        wait_grant(n);
        e = sb.pop_front();
        total++;
        if (n !== 1 || grant_out !== e.g || val_out !== e.v) begin
            bad++;
            $display("FAIL single_regrant: idle=%0d g=%b val=%h expected idle=1 g=%b val=%h", n, grant_out, val_out, e.g, e.v);
        end
        req_in = '0;
    endtask

    task automatic test_round_robin;
        exp_t e;
        int n, gc, dc, bc;
        logic [3:0] d;
        do_reset;
        for (int i = 0; i < 4; i++) val_in[32*i +: 32] = 32'h1111_1111 * (i + 1);
        req_in = 4'b1111;
        for (int k = 0; k < 5; k++) push(4'(1 << (k % 4)), 32'h1111_1111 * ((k % 4) + 1), 4, 4'(1 << (k % 4)), 2);
        for (int k = 0; k < 5; k++) begin
            wait_grant(n);
            e = sb.pop_front();
            total++;
            if (grant_out !== e.g || val_out !== e.v || (k > 0 && n !== 1)) begin
                bad++;
                $display("FAIL rr_grant%0d: g=%b val=%h idle=%0d expected g=%b val=%h idle=1", k, grant_out, val_out, n, e.g, e.v);
            end
            measure(gc, d, dc, bc);
            total++;
            if (gc !== e.gc || bc !== e.bc || d !== e.d || dc !== 1) begin
                bad++;
                $display("FAIL rr_slot%0d: dwell=%0d gap=%0d done=%b x%0d expected dwell=%0d gap=%0d done=%b x1",
                         k, gc, bc, d, dc, e.gc, e.bc, e.d);
            end
        end
        req_in = '0;
    endtask

    task automatic test_hold_value;
        exp_t e;
        int n, gc, dc, bc;
        logic [3:0] d;
        do_reset;
        val_in[0 +: 32] = 32'h1111_0000;
        req_in = 4'b0001;
        push(4'b0001, 32'h1111_0000, 4, 4'b0001, 2);
        push(4'b0001, 32'hAAAA_AAAA, 4, 4'b0001, 2);
        wait_grant(n);
        e = sb.pop_front();
        val_in[0 +: 32] = 32'hAAAA_AAAA;
        total++;
        if (grant_out !== e.g || val_out !== e.v) begin
            bad++;
            $display("FAIL hold_grant: g=%b val=%h expected g=%b val=%h", grant_out, val_out, e.g, e.v);
        end
        measure(gc, d, dc, bc);
        total++;
        if (gc !== e.gc || val_out !== e.v) begin
            bad++;
            $display("FAIL hold_snapshot: dwell=%0d val=%h expected dwell=%0d val=%h", gc, val_out, e.gc, e.v);
        end
        wait_grant(n);
        e = sb.pop_front();
        total++;
        if (grant_out !== e.g || val_out !== e.v) begin
            bad++;
            $display("FAIL hold_newval: g=%b val=%h expected g=%b val=%h", grant_out, val_out, e.g, e.v);
        end
        req_in = '0;
    endtask

    task automatic test_withdraw;
        exp_t e;
        int n, gc, dc, bc;
        logic [3:0] d;
        do_reset;
        val_in[64 +: 32] = 32'hCAFE_0002;
        req_in = 4'b0100;
        push(4'b0100, 32'hCAFE_0002, 0, 4'b0000, 2);
        wait_grant(n);
        e = sb.pop_front();
        total++;
        if (grant_out !== e.g || val_out !== e.v) begin
            bad++;
            $display("FAIL wd_grant: g=%b val=%h expected g=%b val=%h", grant_out, val_out, e.g, e.v);
        end
        @(negedge clk_in);
        req_in = 4'b0000;
        @(negedge clk_in);
        total++;
        if (grant_out !== 4'b0 || done_out !== 4'b0 || blank_out !== 1'b1) begin
            bad++;
            $display("FAIL wd_drop: g=%b d=%b blank=%b expected g=0000 d=0000 blank=1", grant_out, done_out, blank_out);
        end
        total++;
        if ({z_grant, z_done, z_blank, z_busy} !== 10'b0 || z_val !== e.v) begin
            bad++;
            $display("FAIL wd_nogap: g=%b d=%b blank=%b busy=%b val=%h expected zeros val=%h",
                     z_grant, z_done, z_blank, z_busy, z_val, e.v);
        end
        measure(gc, d, dc, bc);
        total++;
        if (gc !== e.gc || bc !== e.bc || d !== e.d || dc !== 0) begin
            bad++;
            $display("FAIL wd_gap: grant=%0d gap=%0d done=%b x%0d expected grant=%0d gap=%0d done=%b x0",
                     gc, bc, d, dc, e.gc, e.bc, e.d);
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        int n;
        do_reset;
        val_in[0 +: 32]  = 32'h0BAD_0001;
        val_in[96 +: 32] = 32'h0BAD_0003;
        req_in = 4'b0001;
        push(4'b0001, 32'h0BAD_0001, 4, 4'b0001, 2);
        push(4'b0001, 32'h0BAD_0001, 4, 4'b0001, 2);
        wait_grant(n);
        e = sb.pop_front();
        total++;
        if (grant_out !== e.g || val_out !== e.v) begin
            bad++;
            $display("FAIL ar_grant: g=%b val=%h expected g=%b val=%h", grant_out, val_out, e.g, e.v);
        end
        @(negedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        total++;
        if (val_out !== 32'hDEAD_BEEF || {grant_out, done_out, busy_out, blank_out} !== 10'b0) begin
            bad++;
            $display("FAIL ar_immediate: val=%h g=%b d=%b busy=%b blank=%b expected val=deadbeef all zero",
                     val_out, grant_out, done_out, busy_out, blank_out);
        end
        @(negedge clk_in);
        req_in = 4'b1001;
        rst_in = 1'b1;
        wait_grant(n);
        e = sb.pop_front();
        total++;
        if (grant_out !== e.g || val_out !== e.v) begin
            bad++;
            $display("FAIL ar_ptr_zero: g=%b val=%h expected g=%b val=%h", grant_out, val_out, e.g, e.v);
        end
        req_in = 4'b1000;
        do_reset;
        req_in = 4'b1000;
        wait_grant(n);
        total++;
        if (grant_out !== 4'b1000 || val_out !== 32'h0BAD_0003) begin
            bad++;
            $display("FAIL ar_req3: g=%b val=%h expected g=1000 val=0bad0003", grant_out, val_out);
        end
        req_in = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_hold_value;
        test_withdraw;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
